// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and sizing constants.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Core-side load/store bus between the MIPS pipeline (master) and the data-memory responder (slave).
interface dmem_responder_if;

    logic        memread;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwritedata;
    logic [31:0] memreaddata;
    logic        stall;
    logic        addr_err;
    logic        proto_err;

    modport master (
        output memread, memwrite, memaddr, memwritedata,
        input  memreaddata, stall, addr_err, proto_err
    );

    modport slave (
        input  memread, memwrite, memaddr, memwritedata,
        output memreaddata, stall, addr_err, proto_err
    );

endinterface

// File: rtl/dmem_responder_array.sv
// Word storage with synchronous write and a registered read port that can also be forced to zero.
module dmem_array #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic                     re,
    input  logic                     rclr,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    // NOTE: storage has no reset so it maps onto RAM; only the read register below is reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= 32'h0;
        end else if (rclr) begin
            rdata <= 32'h0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: wait-state FSM, address checking and sticky error flags around dmem_array.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);

    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [31:0] SPAN  = 32'(DEPTH * WORD_BYTES);

    state_e             state;
    state_e             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               lat_write;
    logic [31:0]        lat_addr;
    logic [31:0]        lat_data;

    logic               req;
    logic               cur_write;
    logic [31:0]        cur_addr;
    logic [31:0]        cur_data;
    logic [31:0]        offset;
    logic               bad;
    logic               commit;
    logic [31:0]        rd_data;

    assign req = bus.memread | bus.memwrite;

    // With zero wait states the commit edge is also the latch edge, so use the live bus.
    assign cur_write = (state == IDLE) ? bus.memwrite     : lat_write;
    assign cur_addr  = (state == IDLE) ? bus.memaddr      : lat_addr;
    assign cur_data  = (state == IDLE) ? bus.memwritedata : lat_data;

    assign offset = cur_addr - BASE_ADDR;
    assign bad    = (cur_addr[1:0] != 2'b00) || (offset >= SPAN);
    assign commit = (state_next == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = (WAIT_CYCLES == 0) ? DONE : WAIT;
            WAIT:    if (cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.stall = 1'b0;
        if ((state == IDLE && req) || state == WAIT) begin
            bus.stall = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_addr  <= 32'h0;
            lat_data  <= 32'h0;
        end else if (state == IDLE && req) begin
            lat_write <= bus.memwrite;
            lat_addr  <= bus.memaddr;
            lat_data  <= bus.memwritedata;
            cnt       <= (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.addr_err  <= 1'b0;
            bus.proto_err <= 1'b0;
        end else begin
            if (commit && bad) begin
                bus.addr_err <= 1'b1;
            end
            if (state == IDLE && bus.memread && bus.memwrite) begin
                bus.proto_err <= 1'b1;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (commit && cur_write && !bad),
        .re    (commit && !cur_write && !bad),
        .rclr  (commit && !cur_write && bad),
        .idx   (offset[IDX_W+1:2]),
        .wdata (cur_data),
        .rdata (rd_data)
    );

    assign bus.memreaddata = rd_data;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (2, 0 and 1 wait states) driven by directed steps.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    logic        rd [3];
    logic        wr [3];
    logic [31:0] ad [3];
    logic [31:0] wd [3];
    logic [31:0] last_rd [3];
    logic [31:0] exp_q [$];

    localparam int WC_TAB [3] = '{2, 0, 1};

    int compared   = 0;
    int mismatched = 0;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();
    dmem_responder_if bus2 ();

    assign bus0.memread = rd[0]; assign bus0.memwrite = wr[0];
    assign bus0.memaddr = ad[0]; assign bus0.memwritedata = wd[0];
    assign bus1.memread = rd[1]; assign bus1.memwrite = wr[1];
    assign bus1.memaddr = ad[1]; assign bus1.memwritedata = wd[1];
    assign bus2.memread = rd[2]; assign bus2.memwrite = wr[2];
    assign bus2.memaddr = ad[2]; assign bus2.memwritedata = wd[2];

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    function automatic logic get_stall(input int k);
        case (k)
            0:       return bus0.stall;
            1:       return bus1.stall;
            default: return bus2.stall;
        endcase
    endfunction

    function automatic logic [31:0] get_rdata(input int k);
        case (k)
            0:       return bus0.memreaddata;
            1:       return bus1.memreaddata;
            default: return bus2.memreaddata;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One core access on instance k; exp_rd is the load result the core should see in DONE.
    task automatic access(input int k, input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd, input logic glitch);
        int n;
        wr[k] = w; rd[k] = r; ad[k] = a; wd[k] = d;
        if (r && !w) last_rd[k] = exp_rd;
        exp_q.push_back(last_rd[k]);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!get_stall(k)) break;
            n++;
            if (glitch && n == 2) begin
                ad[k] = a ^ 32'h4;
                wd[k] = ~d;
            end
        end
        chk($sformatf("stall_cycles[%0d]@%h", k, a), 32'(n), 32'(WC_TAB[k] + 1));
        chk($sformatf("rdata[%0d]@%h", k, a), get_rdata(k), exp_q.pop_front());
        @(posedge clk); #1;
        rd[k] = 1'b0; wr[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rd[k] = 1'b0; wr[k] = 1'b0; ad[k] = 32'h0; wd[k] = 32'h0; last_rd[k] = 32'h0;
        end
        reset = 1'b1;
        #3;
        chk("reset_stall", 32'(bus0.stall), 32'h0);
        chk("reset_rdata", bus0.memreaddata, 32'h0);
        chk("reset_addr_err", 32'(bus0.addr_err), 32'h0);
        chk("reset_proto_err", 32'(bus0.proto_err), 32'h0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // Zero wait states: single stall cycle.
        access(1, 1'b1, 1'b0, 32'h0, 32'h1234_5678, 32'h0, 1'b0);
        access(1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h1234_5678, 1'b0);

        // One wait state: back-to-back loads with the address disturbed during WAIT.
        access(2, 1'b1, 1'b0, 32'h0, 32'hA0A0_0001, 32'h0, 1'b0);
        access(2, 1'b1, 1'b0, 32'h4, 32'hB0B0_0002, 32'h0, 1'b0);
        access(2, 1'b0, 1'b1, 32'h0, 32'h0, 32'hA0A0_0001, 1'b1);
        access(2, 1'b0, 1'b1, 32'h4, 32'h0, 32'hB0B0_0002, 1'b1);
        chk("wc1_addr_err", 32'(bus2.addr_err), 32'h0);

        // Two wait states: store/load, then misaligned and out-of-range accesses.
        access(0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        access(0, 1'b0, 1'b1, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        chk("clean_addr_err", 32'(bus0.addr_err), 32'h0);
        access(0, 1'b1, 1'b0, 32'h13, 32'hFFFF_FFFF, 32'h0, 1'b0);
        chk("misaligned_addr_err", 32'(bus0.addr_err), 32'h1);
        access(0, 1'b0, 1'b1, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        access(0, 1'b0, 1'b1, 32'h100, 32'h0, 32'h0, 1'b0);
        chk("range_addr_err", 32'(bus0.addr_err), 32'h1);
        chk("no_proto_err_yet", 32'(bus0.proto_err), 32'h0);

        // Both strobes high: performed as a write and flagged.
        access(0, 1'b1, 1'b1, 32'h8, 32'hA5A5_A5A5, 32'h0, 1'b0);
        chk("proto_err", 32'(bus0.proto_err), 32'h1);
        access(0, 1'b0, 1'b1, 32'h8, 32'h0, 32'hA5A5_A5A5, 1'b0);

        // Reset during the second WAIT cycle of a store must abort it.
        access(0, 1'b1, 1'b0, 32'h20, 32'h1, 32'h0, 1'b0);
        wr[0] = 1'b1; ad[0] = 32'h20; wd[0] = 32'hBAD0_0BAD;
        @(posedge clk);
        @(posedge clk); #2;
        chk("wait2_stall", 32'(bus0.stall), 32'h1);
        reset = 1'b1; wr[0] = 1'b0;
        #1;
        chk("abort_stall", 32'(bus0.stall), 32'h0);
        chk("abort_addr_err", 32'(bus0.addr_err), 32'h0);
        chk("abort_proto_err", 32'(bus0.proto_err), 32'h0);
        chk("abort_rdata", bus0.memreaddata, 32'h0);
        last_rd[0] = 32'h0;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        access(0, 1'b0, 1'b1, 32'h20, 32'h0, 32'h1, 1'b0);
        chk("final_addr_err", 32'(bus0.addr_err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
